// File: rtl/mult_wb_arbiter.sv
// Merges mult5 results with the ALU writeback stream onto the single register-file write port.
// MULT_WB_BYPASS_EN lets a lone mult5 result skip the empty buffer with 1-cycle latency.
module mult_wb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 32
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              kill_i,
    input  logic [DATA_W-1:0] mult5_int_write_data_i,
    input  logic [4:0]        mult5_write_addr_i,
    input  logic              mult5_int_write_enable_i,
    input  logic [DATA_W-1:0] mult5_instruction_i,
    input  logic [DATA_W-1:0] mult5_pc_i,
    input  logic [DATA_W-1:0] alu_int_write_data_i,
    input  logic [4:0]        alu_write_addr_i,
    input  logic              alu_int_write_enable_i,
    input  logic [DATA_W-1:0] alu_instruction_i,
    input  logic [DATA_W-1:0] alu_pc_i,
    output logic [DATA_W-1:0] rf_write_data_o,
    output logic [4:0]        rf_write_addr_o,
    output logic              rf_write_enable_o,
    output logic [DATA_W-1:0] wb_instruction_o,
    output logic [DATA_W-1:0] wb_pc_o,
    output logic              mult_stall_o,
    output logic              alu_stall_o,
    output logic [3:0]        mult_pending_o
);

    localparam int              PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [3:0]       CNT_FULL = 4'(FIFO_DEPTH);

    logic [DATA_W-1:0] fifo_data  [FIFO_DEPTH];
    logic [4:0]        fifo_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_instr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_pc    [FIFO_DEPTH];

    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [3:0]        count;

    logic              fifo_full, fifo_empty, mult_accept;
    logic              enq, deq, win_vld;
    logic [DATA_W-1:0] win_data, win_instr, win_pc;
    logic [4:0]        win_addr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_full      = (count == CNT_FULL);
    assign fifo_empty     = (count == 4'd0);
    assign mult_accept    = mult5_int_write_enable_i && !fifo_full;
    assign mult_stall_o   = fifo_full;
    assign alu_stall_o    = fifo_full && alu_int_write_enable_i;
    assign mult_pending_o = count;

    // Arbitration from start-of-cycle state; a full buffer drains before the ALU.
    always_comb begin
        enq       = 1'b0;
        deq       = 1'b0;
        win_vld   = 1'b0;
        win_data  = '0;
        win_addr  = '0;
        win_instr = '0;
        win_pc    = '0;
        if (fifo_full) begin
            deq       = 1'b1;
            win_vld   = 1'b1;
            win_data  = fifo_data[rd_ptr];
            win_addr  = fifo_addr[rd_ptr];
            win_instr = fifo_instr[rd_ptr];
            win_pc    = fifo_pc[rd_ptr];
        end else if (alu_int_write_enable_i) begin
            enq       = mult_accept;
            win_vld   = 1'b1;
            win_data  = alu_int_write_data_i;
            win_addr  = alu_write_addr_i;
            win_instr = alu_instruction_i;
            win_pc    = alu_pc_i;
        end else if (!fifo_empty) begin
            enq       = mult_accept;
            deq       = 1'b1;
            win_vld   = 1'b1;
            win_data  = fifo_data[rd_ptr];
            win_addr  = fifo_addr[rd_ptr];
            win_instr = fifo_instr[rd_ptr];
            win_pc    = fifo_pc[rd_ptr];
        end else if (mult_accept) begin
`ifdef MULT_WB_BYPASS_EN
            win_vld   = 1'b1;
            win_data  = mult5_int_write_data_i;
            win_addr  = mult5_write_addr_i;
            win_instr = mult5_instruction_i;
            win_pc    = mult5_pc_i;
`else
            enq       = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq && !kill_i) begin
            fifo_data[wr_ptr]  <= mult5_int_write_data_i;
            fifo_addr[wr_ptr]  <= mult5_write_addr_i;
            fifo_instr[wr_ptr] <= mult5_instruction_i;
            fifo_pc[wr_ptr]    <= mult5_pc_i;
        end
    end

    // Output register stage: winner lands on the write port one edge later.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            count             <= 4'd0;
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            rf_write_enable_o <= 1'b0;
            rf_write_data_o   <= '0;
            rf_write_addr_o   <= '0;
            wb_instruction_o  <= '0;
            wb_pc_o           <= '0;
        end else if (kill_i) begin
            count             <= 4'd0;
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            rf_write_enable_o <= 1'b0;
            rf_write_data_o   <= '0;
            rf_write_addr_o   <= '0;
            wb_instruction_o  <= '0;
            wb_pc_o           <= '0;
        end else begin
            if (enq && !deq)
                count <= count + 4'd1;
            else if (deq && !enq)
                count <= count - 4'd1;
            if (enq)
                wr_ptr <= next_ptr(wr_ptr);
            if (deq)
                rd_ptr <= next_ptr(rd_ptr);
            rf_write_enable_o <= win_vld && (win_addr != 5'd0);
            rf_write_data_o   <= win_data;
            rf_write_addr_o   <= win_addr;
            wb_instruction_o  <= win_instr;
            wb_pc_o           <= win_pc;
        end
    end

endmodule

// File: tb/tb_mult_wb_arbiter.sv
// Directed bench for mult_wb_arbiter: vector table plus hand-written reset/latency sequences.
module tb_mult_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rsn_i;
    logic        kill_i;
    logic [31:0] mult5_int_write_data_i, mult5_instruction_i, mult5_pc_i;
    logic [4:0]  mult5_write_addr_i;
    logic        mult5_int_write_enable_i;
    logic [31:0] alu_int_write_data_i, alu_instruction_i, alu_pc_i;
    logic [4:0]  alu_write_addr_i;
    logic        alu_int_write_enable_i;
    logic [31:0] rf_write_data_o, wb_instruction_o, wb_pc_o;
    logic [4:0]  rf_write_addr_o;
    logic        rf_write_enable_o, mult_stall_o, alu_stall_o;
    logic [3:0]  mult_pending_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    mult_wb_arbiter #(.FIFO_DEPTH(2), .DATA_W(32)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .kill_i(kill_i),
        .mult5_int_write_data_i(mult5_int_write_data_i),
        .mult5_write_addr_i(mult5_write_addr_i),
        .mult5_int_write_enable_i(mult5_int_write_enable_i),
        .mult5_instruction_i(mult5_instruction_i),
        .mult5_pc_i(mult5_pc_i),
        .alu_int_write_data_i(alu_int_write_data_i),
        .alu_write_addr_i(alu_write_addr_i),
        .alu_int_write_enable_i(alu_int_write_enable_i),
        .alu_instruction_i(alu_instruction_i),
        .alu_pc_i(alu_pc_i),
        .rf_write_data_o(rf_write_data_o),
        .rf_write_addr_o(rf_write_addr_o),
        .rf_write_enable_o(rf_write_enable_o),
        .wb_instruction_o(wb_instruction_o),
        .wb_pc_o(wb_pc_o),
        .mult_stall_o(mult_stall_o),
        .alu_stall_o(alu_stall_o),
        .mult_pending_o(mult_pending_o)
    );

    typedef struct {
        logic        kill;
        logic        aw;
        logic [4:0]  aa;
        logic [31:0] ad, ap;
        logic        mw;
        logic [4:0]  ma;
        logic [31:0] md, mp;
        logic        xms, xas;
        logic        xwe;
        logic [4:0]  xa;
        logic [31:0] xd, xp;
        logic [3:0]  xpend;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic kill, input logic aw, input logic [4:0] aa,
                                input logic [31:0] ad, input logic [31:0] ap,
                                input logic mw, input logic [4:0] ma,
                                input logic [31:0] md, input logic [31:0] mp,
                                input logic xms, input logic xas, input logic xwe,
                                input logic [4:0] xa, input logic [31:0] xd,
                                input logic [31:0] xp, input logic [3:0] xpend);
        vec_t v;
        v.kill = kill; v.aw = aw; v.aa = aa; v.ad = ad; v.ap = ap;
        v.mw = mw; v.ma = ma; v.md = md; v.mp = mp;
        v.xms = xms; v.xas = xas; v.xwe = xwe; v.xa = xa; v.xd = xd; v.xp = xp;
        v.xpend = xpend;
        return v;
    endfunction

    // Instruction words are the complement of the PC so both fields are distinguishable.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return (pc == 32'd0) ? 32'd0 : ~pc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        kill_i = 0;
        alu_int_write_enable_i = 0; alu_write_addr_i = 0; alu_int_write_data_i = 0;
        alu_pc_i = 0; alu_instruction_i = 0;
        mult5_int_write_enable_i = 0; mult5_write_addr_i = 0; mult5_int_write_data_i = 0;
        mult5_pc_i = 0; mult5_instruction_i = 0;
    endtask

    task automatic check_outputs(input string tag, input logic we, input logic [4:0] a,
                                 input logic [31:0] d, input logic [31:0] pc,
                                 input logic [3:0] pend);
        chk({tag, "_we"},    32'(rf_write_enable_o), 32'(we));
        chk({tag, "_addr"},  32'(rf_write_addr_o), 32'(a));
        chk({tag, "_data"},  rf_write_data_o, d);
        chk({tag, "_pc"},    wb_pc_o, pc);
        chk({tag, "_instr"}, wb_instruction_o, instr_of(pc));
        chk({tag, "_pend"},  32'(mult_pending_o), 32'(pend));
    endtask

    initial begin
        // ALU and mult in the same cycle: ALU first, mult next.
        vecs[0]  = mk(0, 1, 5'd3, 32'h11, 32'h200, 1, 5'd4, 32'h22, 32'h204, 0, 0, 1, 5'd3, 32'h11, 32'h200, 4'd1);
        vecs[1]  = mk(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 1, 5'd4, 32'h22, 32'h204, 4'd0);
        vecs[2]  = mk(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 4'd0);
        // Continuous ALU with three mult results into a 2-entry buffer.
        vecs[3]  = mk(0, 1, 5'd1, 32'hA1, 32'h300, 1, 5'd10, 32'hB001, 32'h400, 0, 0, 1, 5'd1, 32'hA1, 32'h300, 4'd1);
        vecs[4]  = mk(0, 1, 5'd2, 32'hA2, 32'h304, 1, 5'd11, 32'hB002, 32'h404, 0, 0, 1, 5'd2, 32'hA2, 32'h304, 4'd2);
        vecs[5]  = mk(0, 1, 5'd6, 32'hA3, 32'h308, 1, 5'd12, 32'hB003, 32'h408, 1, 1, 1, 5'd10, 32'hB001, 32'h400, 4'd1);
        vecs[6]  = mk(0, 1, 5'd6, 32'hA3, 32'h308, 1, 5'd12, 32'hB003, 32'h408, 0, 0, 1, 5'd6, 32'hA3, 32'h308, 4'd2);
        vecs[7]  = mk(0, 1, 5'd7, 32'hA4, 32'h30C, 0, 5'd0, 32'h0, 32'h0, 1, 1, 1, 5'd11, 32'hB002, 32'h404, 4'd1);
        vecs[8]  = mk(0, 1, 5'd7, 32'hA4, 32'h30C, 0, 5'd0, 32'h0, 32'h0, 0, 0, 1, 5'd7, 32'hA4, 32'h30C, 4'd1);
        vecs[9]  = mk(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 1, 5'd12, 32'hB003, 32'h408, 4'd0);
        // ALU write to x0 retires without a register write.
        vecs[10] = mk(0, 1, 5'd0, 32'hFFFF, 32'h500, 0, 5'd0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'hFFFF, 32'h500, 4'd0);
        // Fill the buffer, then kill: nothing buffered may retire.
        vecs[11] = mk(0, 1, 5'd1, 32'hC1, 32'h600, 1, 5'd13, 32'hD001, 32'h700, 0, 0, 1, 5'd1, 32'hC1, 32'h600, 4'd1);
        vecs[12] = mk(0, 1, 5'd2, 32'hC2, 32'h604, 1, 5'd14, 32'hD002, 32'h704, 0, 0, 1, 5'd2, 32'hC2, 32'h604, 4'd2);
        vecs[13] = mk(1, 1, 5'd3, 32'hC3, 32'h608, 1, 5'd15, 32'hD003, 32'h708, 1, 1, 0, 5'd0, 32'h0, 32'h0, 4'd0);
        vecs[14] = mk(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 4'd0);
        vecs[15] = mk(0, 0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 4'd0);

        idle_inputs();
        rsn_i = 0;
        #12;
        check_outputs("reset", 0, 5'd0, 32'h0, 32'h0, 4'd0);
        chk("reset_mstall", 32'(mult_stall_o), 32'd0);
        chk("reset_astall", 32'(alu_stall_o), 32'd0);
        rsn_i = 1;
        tick();

        // Lone mult result after reset.
        mult5_int_write_enable_i = 1; mult5_write_addr_i = 5'd5;
        mult5_int_write_data_i = 32'hDEADBEEF; mult5_pc_i = 32'h100;
        mult5_instruction_i = instr_of(32'h100);
        tick();
        idle_inputs();
`ifdef MULT_WB_BYPASS_EN
        check_outputs("lone_c1", 1, 5'd5, 32'hDEADBEEF, 32'h100, 4'd0);
`else
        check_outputs("lone_c1", 0, 5'd0, 32'h0, 32'h0, 4'd1);
        tick();
        check_outputs("lone_c2", 1, 5'd5, 32'hDEADBEEF, 32'h100, 4'd0);
`endif
        tick();
        check_outputs("lone_idle", 0, 5'd0, 32'h0, 32'h0, 4'd0);

        for (int i = 0; i < 16; i++) begin
            kill_i = vecs[i].kill;
            alu_int_write_enable_i = vecs[i].aw; alu_write_addr_i = vecs[i].aa;
            alu_int_write_data_i = vecs[i].ad; alu_pc_i = vecs[i].ap;
            alu_instruction_i = instr_of(vecs[i].ap);
            mult5_int_write_enable_i = vecs[i].mw; mult5_write_addr_i = vecs[i].ma;
            mult5_int_write_data_i = vecs[i].md; mult5_pc_i = vecs[i].mp;
            mult5_instruction_i = instr_of(vecs[i].mp);
            #1;
            chk($sformatf("v%0d_mstall", i), 32'(mult_stall_o), 32'(vecs[i].xms));
            chk($sformatf("v%0d_astall", i), 32'(alu_stall_o), 32'(vecs[i].xas));
            tick();
            check_outputs($sformatf("v%0d", i), vecs[i].xwe, vecs[i].xa, vecs[i].xd,
                          vecs[i].xp, vecs[i].xpend);
        end
        idle_inputs();

        // Asynchronous reset mid-cycle with two buffered entries.
        alu_int_write_enable_i = 1; alu_write_addr_i = 5'd8; alu_int_write_data_i = 32'hE1;
        alu_pc_i = 32'h800; alu_instruction_i = instr_of(32'h800);
        mult5_int_write_enable_i = 1; mult5_write_addr_i = 5'd16; mult5_int_write_data_i = 32'hF1;
        mult5_pc_i = 32'h900; mult5_instruction_i = instr_of(32'h900);
        tick();
        alu_write_addr_i = 5'd9; alu_int_write_data_i = 32'hE2;
        alu_pc_i = 32'h804; alu_instruction_i = instr_of(32'h804);
        mult5_write_addr_i = 5'd17; mult5_int_write_data_i = 32'hF2;
        mult5_pc_i = 32'h904; mult5_instruction_i = instr_of(32'h904);
        tick();
        idle_inputs();
        check_outputs("pre_arst", 1, 5'd9, 32'hE2, 32'h804, 4'd2);
        #2;
        rsn_i = 0;
        #1;
        check_outputs("arst_async", 0, 5'd0, 32'h0, 32'h0, 4'd0);
        chk("arst_mstall", 32'(mult_stall_o), 32'd0);
        #1;
        rsn_i = 1;
        tick();
        check_outputs("arst_post1", 0, 5'd0, 32'h0, 32'h0, 4'd0);
        tick();
        check_outputs("arst_post2", 0, 5'd0, 32'h0, 32'h0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
